// File: rtl/red_operand_feeder_if.sv
// Operand/result bundle between the operand feeder (master) and the nibble
// reduction datapath (slave).
interface red_operand_feeder_if;
  logic        start;
  logic [15:0] rs_out;
  logic [15:0] rt_out;
  logic        op_valid;
  logic [6:0]  rd_in;
  logic        busy;
  logic        mismatch;
  logic [7:0]  pass_count;
  logic [7:0]  fail_count;
  logic        done;

  modport master (
    input  start, rd_in,
    output rs_out, rt_out, op_valid, busy, mismatch, pass_count, fail_count, done
  );

  modport slave (
    output start, rd_in,
    input  rs_out, rt_out, op_valid, busy, mismatch, pass_count, fail_count, done
  );
endinterface

// File: rtl/red_operand_feeder.sv
// Self-checking operand source for the nibble reduction unit: LFSR operands,
// serial reference sum, rd compare. Optional macro REDFEED_DIRECTED_EN adds
// two directed corner vectors (all-ones, all-zeros) at the start of each run.
module red_operand_feeder #(
  parameter int          NUM_VECTORS = 5,
  parameter logic [31:0] SEED        = 32'hACE1_1234
) (
  input logic                  clk,
  input logic                  rst,
  red_operand_feeder_if.master bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE   = 2'd1;
  localparam logic [1:0] COMPARE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'h1 : SEED;
  localparam logic [7:0]  LAST_VEC = 8'(NUM_VECTORS - 1);

  logic [1:0]  r_state;
  logic [31:0] r_lfsr;
  logic [15:0] r_rs;
  logic [15:0] r_rt;
  logic [2:0]  r_idx;
  logic [6:0]  r_acc;
  logic [7:0]  r_vec;
  logic [7:0]  r_pass;
  logic [7:0]  r_fail;

  logic [31:0] w_lfsrNext;
  logic [15:0] w_word;
  logic [3:0]  w_nibble;
  logic        w_hit;
  logic [7:0]  w_vecNext;
  logic [31:0] w_startOps;
  logic [31:0] w_nextOps;
  logic [31:0] w_nextLfsr;

  assign w_lfsrNext = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};
  assign w_word     = r_idx[2] ? r_rt : r_rs;
  assign w_nibble   = w_word[{r_idx[1:0], 2'b00} +: 4];
  assign w_hit      = (bus.rd_in == r_acc);
  assign w_vecNext  = r_vec + 8'd1;

  // Operand words are {rt, rs}; directed vectors leave the LFSR untouched.
  always_comb begin
    w_startOps = r_lfsr;
    w_nextOps  = w_lfsrNext;
    w_nextLfsr = w_lfsrNext;
`ifdef REDFEED_DIRECTED_EN
    w_startOps = 32'hFFFF_FFFF;
    if (w_vecNext == 8'd1) begin
      w_nextOps  = 32'h0000_0000;
      w_nextLfsr = r_lfsr;
    end else if (w_vecNext == 8'd2) begin
      w_nextOps  = r_lfsr;
      w_nextLfsr = r_lfsr;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lfsr  <= SEED_EFF;
      r_rs    <= 16'd0;
      r_rt    <= 16'd0;
      r_idx   <= 3'd0;
      r_acc   <= 7'd0;
      r_vec   <= 8'd0;
      r_pass  <= 8'd0;
      r_fail  <= 8'd0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            r_state      <= DRIVE;
            {r_rt, r_rs} <= w_startOps;
            r_idx        <= 3'd0;
            r_acc        <= 7'd0;
            r_vec        <= 8'd0;
            r_pass       <= 8'd0;
            r_fail       <= 8'd0;
          end
        end
        DRIVE: begin
          r_acc <= r_acc + {3'b000, w_nibble};
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7) r_state <= COMPARE;
        end
        COMPARE: begin
          if (w_hit) begin
            if (r_pass != 8'hFF) r_pass <= r_pass + 8'd1;
          end else begin
            if (r_fail != 8'hFF) r_fail <= r_fail + 8'd1;
          end
          if (r_vec == LAST_VEC) begin
            r_state <= DONE;
          end else begin
            r_state      <= DRIVE;
            {r_rt, r_rs} <= w_nextOps;
            r_lfsr       <= w_nextLfsr;
            r_vec        <= w_vecNext;
            r_idx        <= 3'd0;
            r_acc        <= 7'd0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rs_out     = r_rs;
  assign bus.rt_out     = r_rt;
  assign bus.op_valid   = (r_state == DRIVE) || (r_state == COMPARE);
  assign bus.busy       = (r_state == DRIVE) || (r_state == COMPARE);
  assign bus.done       = (r_state == DONE);
  assign bus.mismatch   = (r_state == COMPARE) && !w_hit;
  assign bus.pass_count = r_pass;
  assign bus.fail_count = r_fail;

endmodule

// File: tb/tb_red_operand_feeder.sv
// Directed, table-driven bench for red_operand_feeder: one 5-vector instance
// for run/reset/restart checks and one 255-vector instance for count saturation.
module tb_red_operand_feeder;

  localparam int          NVA  = 5;
  localparam int          NVB  = 255;
  localparam logic [31:0] SEED = 32'hACE1_1234;
`ifdef REDFEED_DIRECTED_EN
  localparam bit DIRECTED = 1'b1;
  localparam int SEEDIDX  = 2;
`else
  localparam bit DIRECTED = 1'b0;
  localparam int SEEDIDX  = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  red_operand_feeder_if busA ();
  red_operand_feeder_if busB ();

  int rdModeA = 0;
  int rdModeB = 2;

  // Reference reduction unit: 0 = correct sum, 1 = tied to zero, 2 = sum+1.
  function automatic logic [6:0] rdFn(input int mode, input logic [15:0] a, input logic [15:0] b);
    int s;
    s = 0;
    for (int k = 0; k < 4; k++) s += int'(a[k*4 +: 4]) + int'(b[k*4 +: 4]);
    if (mode == 1) return 7'd0;
    if (mode == 2) return 7'(s + 1);
    return 7'(s);
  endfunction

  function automatic logic [31:0] lfsrStep(input logic [31:0] x);
    return {x[30:0], x[31] ^ x[21] ^ x[1] ^ x[0]};
  endfunction

  assign busA.rd_in = rdFn(rdModeA, busA.rs_out, busA.rt_out);
  assign busB.rd_in = rdFn(rdModeB, busB.rs_out, busB.rt_out);

  red_operand_feeder #(.NUM_VECTORS(NVA), .SEED(SEED)) dutA (.clk(clk), .rst(rst), .bus(busA));
  red_operand_feeder #(.NUM_VECTORS(NVB), .SEED(SEED)) dutB (.clk(clk), .rst(rst), .bus(busB));

  int vectorsApplied = 0;
  int miscompares    = 0;

  logic [15:0] seenRs [NVA];
  logic [15:0] seenRt [NVA];
  int doneAt, mmCount, firstMm, unstable;

  typedef struct {
    int rdMode;
    int expPass;
    int expFail;
    int expMm;
    int expFirstMm;
  } runVec_t;

  runVec_t runTable [3];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst        = 1'b1;
    busA.start = 1'b0;
    busB.start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts a run on instance A and records, per negedge i after the start
  // edge, operand stability, mismatch pulses and the first done.
  task automatic applyStimulus(input bit holdStart, input int budget);
    int v;
    doneAt     = -1;
    mmCount    = 0;
    firstMm    = -1;
    unstable   = 0;
    busA.start = 1'b1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (!holdStart) busA.start = 1'b0;
      if (i <= 9 * NVA) begin
        v = (i - 1) / 9;
        if (busA.op_valid !== 1'b1) unstable++;
        else if ((i - 1) % 9 == 0) begin
          seenRs[v] = busA.rs_out;
          seenRt[v] = busA.rt_out;
        end else if (busA.rs_out !== seenRs[v] || busA.rt_out !== seenRt[v]) unstable++;
      end
      if (busA.mismatch === 1'b1) begin
        mmCount++;
        if (firstMm < 0) firstMm = i;
      end
      if (busA.done === 1'b1) begin
        doneAt = i;
        break;
      end
    end
  endtask

  task automatic waitDone(input bit useB, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((useB ? busB.done : busA.done) === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [31:0] m;
    logic [31:0] expOps;
    bit seen;

    runTable[0] = '{0, 5, 0, 0, -1};
`ifdef REDFEED_DIRECTED_EN
    runTable[1] = '{1, 1, 4, 4, 9};
`else
    runTable[1] = '{1, 0, 5, 5, 9};
`endif
    runTable[2] = '{2, 0, 5, 5, 9};

    busA.start = 1'b0;
    busB.start = 1'b0;
    doReset();

    checkOutput("reset op_valid", {31'd0, busA.op_valid}, 32'd0);
    checkOutput("reset busy", {31'd0, busA.busy}, 32'd0);
    checkOutput("reset done", {31'd0, busA.done}, 32'd0);
    checkOutput("reset mismatch", {31'd0, busA.mismatch}, 32'd0);
    checkOutput("reset counts", {16'd0, busA.pass_count, busA.fail_count}, 32'd0);
    checkOutput("reset operands", {busA.rt_out, busA.rs_out}, 32'd0);

    for (int r = 0; r < 3; r++) begin
      rdModeA = runTable[r].rdMode;
      doReset();
      applyStimulus(1'b0, 80);
      checkOutput($sformatf("row%0d done latency", r), doneAt, 9 * NVA + 1);
      checkOutput($sformatf("row%0d pass_count", r), {24'd0, busA.pass_count}, runTable[r].expPass);
      checkOutput($sformatf("row%0d fail_count", r), {24'd0, busA.fail_count}, runTable[r].expFail);
      checkOutput($sformatf("row%0d mismatch pulses", r), mmCount, runTable[r].expMm);
      checkOutput($sformatf("row%0d first mismatch", r), firstMm, runTable[r].expFirstMm);
      checkOutput($sformatf("row%0d operand stability", r), unstable, 0);
      m = SEED;
      for (int v = 0; v < NVA; v++) begin
        if (DIRECTED && v == 0) expOps = 32'hFFFF_FFFF;
        else if (DIRECTED && v == 1) expOps = 32'h0000_0000;
        else begin
          expOps = m;
          m = lfsrStep(m);
        end
        checkOutput($sformatf("row%0d ops v%0d", r, v), {seenRt[v], seenRs[v]}, expOps);
      end
    end

    checkOutput("seed operands", {seenRt[SEEDIDX], seenRs[SEEDIDX]}, 32'hACE1_1234);
    checkOutput("first lfsr step", {seenRt[SEEDIDX+1], seenRs[SEEDIDX+1]}, 32'h59C2_2468);

    rdModeA = 0;
    doReset();
    busA.start = 1'b1;
    @(negedge clk);
    busA.start = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("pre-reset pass_count", {24'd0, busA.pass_count}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun reset busy", {31'd0, busA.busy}, 32'd0);
    checkOutput("midrun reset op_valid", {31'd0, busA.op_valid}, 32'd0);
    checkOutput("midrun reset counts", {16'd0, busA.pass_count, busA.fail_count}, 32'd0);
    checkOutput("midrun reset rs_out", {16'd0, busA.rs_out}, 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("idle after reset", {30'd0, busA.busy, busA.done}, 32'd0);

    doReset();
    applyStimulus(1'b1, 80);
    checkOutput("held start done latency", doneAt, 9 * NVA + 1);
    checkOutput("held start pass_count", {24'd0, busA.pass_count}, 32'd5);
    @(negedge clk);
    checkOutput("restart busy/done", {30'd0, busA.busy, busA.done}, 32'h2);
    checkOutput("restart counts cleared", {16'd0, busA.pass_count, busA.fail_count}, 32'd0);
    m = SEED;
    for (int k = 0; k < NVA - 1; k++) m = lfsrStep(m);
    expOps = DIRECTED ? 32'hFFFF_FFFF : m;
    checkOutput("restart operands", {busA.rt_out, busA.rs_out}, expOps);
    busA.start = 1'b0;
    waitDone(1'b0, 60, seen);
    checkOutput("second run done", {31'd0, seen}, 32'd1);
    checkOutput("second run pass_count", {24'd0, busA.pass_count}, 32'd5);

    busB.start = 1'b1;
    @(negedge clk);
    busB.start = 1'b0;
    waitDone(1'b1, 9 * NVB + 20, seen);
    checkOutput("sat run1 done", {31'd0, seen}, 32'd1);
    checkOutput("sat run1 fail_count", {24'd0, busB.fail_count}, 32'd255);
    checkOutput("sat run1 pass_count", {24'd0, busB.pass_count}, 32'd0);
    busB.start = 1'b1;
    @(negedge clk);
    busB.start = 1'b0;
    checkOutput("sat run2 cleared", {24'd0, busB.fail_count}, 32'd0);
    waitDone(1'b1, 9 * NVB + 20, seen);
    checkOutput("sat run2 done", {31'd0, seen}, 32'd1);
    checkOutput("sat run2 fail_count", {24'd0, busB.fail_count}, 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
